// File: rtl/fractal_sync_tx_mc.sv
// N-channel fractal sync response fan-out: sample stage, per-channel circular FIFOs, overflow tracking.
// Optional per-channel drop counters are enabled by defining FRACTAL_SYNC_TX_MC_DROP_CNT_EN.
module fractal_sync_tx_mc #(
  parameter int unsigned N_CHANNELS = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned RSP_W      = 8,
  parameter bit          COMB_IN    = 1'b0,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rsp_wake_i,
  input  logic [RSP_W-1:0]            rsp_data_i,
  output logic                        check_propagate_o,
  output logic [RSP_W-1:0]            sampled_data_o,
  input  logic [N_CHANNELS-1:0]       propagate_i,
  output logic [N_CHANNELS-1:0]       valid_o,
  output logic [N_CHANNELS*RSP_W-1:0] data_o,
  input  logic [N_CHANNELS-1:0]       ready_i,
  output logic [N_CHANNELS*LVL_W-1:0] level_o,
  output logic [N_CHANNELS-1:0]       overflow_o,
  output logic [N_CHANNELS-1:0]       overflow_sticky_o,
  input  logic                        err_clr_i,
  output logic [N_CHANNELS*16-1:0]    drop_cnt_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Explicit wrap so non-power-of-two depths cycle through 0..FIFO_DEPTH-1 only.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  if (COMB_IN) begin : g_comb_in
    // Gated so the sample path also reads 0 while reset is held.
    assign check_propagate_o = rsp_wake_i & ~rst_i;
    assign sampled_data_o    = rst_i ? '0 : rsp_data_i;
  end else begin : g_reg_in
    logic             wake_q;
    logic [RSP_W-1:0] data_q;
    logic [RSP_W-1:0] data_d;

    always_comb begin
      if (rsp_wake_i) begin
        data_d = rsp_data_i;
      end else begin
        data_d = data_q;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wake_q <= 1'b0;
        data_q <= '0;
      end else begin
        wake_q <= rsp_wake_i;
        data_q <= data_d;
      end
    end

    assign check_propagate_o = wake_q;
    assign sampled_data_o    = data_q;
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    logic [RSP_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             sticky_q, sticky_d;
    logic             push_s, pop_s, full_s, acc_s, ovf_s;

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    always_comb begin
      push_s   = check_propagate_o & propagate_i[c];
      pop_s    = (lvl_q != '0) & ready_i[c];
      full_s   = (lvl_q == LVL_W'(FIFO_DEPTH));
      acc_s    = push_s & (~full_s | pop_s);
      ovf_s    = push_s & full_s & ~pop_s;
      wr_d     = acc_s ? ptr_inc(wr_q) : wr_q;
      rd_d     = pop_s ? ptr_inc(rd_q) : rd_q;
      case ({acc_s, pop_s})
        2'b10:   lvl_d = lvl_q + LVL_W'(1);
        2'b01:   lvl_d = lvl_q - LVL_W'(1);
        default: lvl_d = lvl_q;
      endcase
      if (ovf_s) begin
        sticky_d = 1'b1;
      end else if (err_clr_i) begin
        sticky_d = 1'b0;
      end else begin
        sticky_d = sticky_q;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem_q[i] <= '0;
        end
        wr_q     <= '0;
        rd_q     <= '0;
        lvl_q    <= '0;
        sticky_q <= 1'b0;
      end else begin
        if (acc_s) begin
          mem_q[wr_q] <= sampled_data_o;
        end
        wr_q     <= wr_d;
        rd_q     <= rd_d;
        lvl_q    <= lvl_d;
        sticky_q <= sticky_d;
      end
    end

    assign valid_o[c]                  = (lvl_q != '0);
    assign data_o[c*RSP_W +: RSP_W]    = mem_q[rd_q];
    assign level_o[c*LVL_W +: LVL_W]   = lvl_q;
    assign overflow_o[c]               = ovf_s;
    assign overflow_sticky_o[c]        = sticky_q;

`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
    logic [15:0] cnt_q, cnt_d, cnt_base_s;

    // Clear applies first, so a drop in the clearing cycle is still counted.
    always_comb begin
      if (err_clr_i) begin
        cnt_base_s = 16'd0;
      end else begin
        cnt_base_s = cnt_q;
      end
      if (ovf_s && (cnt_base_s != 16'hFFFF)) begin
        cnt_d = cnt_base_s + 16'd1;
      end else begin
        cnt_d = cnt_base_s;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= 16'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign drop_cnt_o[c*16 +: 16] = cnt_q;
`else
    assign drop_cnt_o[c*16 +: 16] = 16'd0;
`endif
  end

endmodule

// File: tb/tb_fractal_sync_tx_mc.sv
// Self-checking bench for fractal_sync_tx_mc: directed vector table, reset/wrap sequences, random vs. queue model.
module tb_fractal_sync_tx_mc;

  localparam int D = 2;
`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wake, clr;
  logic [7:0]  din;
  logic [1:0]  prop, ready;
  logic        cp;
  logic [7:0]  sd;
  logic [1:0]  valid, ovf, sticky;
  logic [15:0] dout;
  logic [3:0]  lvl;
  logic [31:0] cnt;

  logic        b_wake, b_prop, b_ready, b_clr;
  logic [7:0]  b_din, b_sd, b_dout;
  logic        b_cp, b_valid, b_ovf, b_sticky;
  logic [1:0]  b_lvl;
  logic [15:0] b_cnt;

  always #5 clk = ~clk;

  fractal_sync_tx_mc #(.N_CHANNELS(2), .FIFO_DEPTH(2), .RSP_W(8), .COMB_IN(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .rsp_wake_i(wake), .rsp_data_i(din),
    .check_propagate_o(cp), .sampled_data_o(sd), .propagate_i(prop),
    .valid_o(valid), .data_o(dout), .ready_i(ready), .level_o(lvl),
    .overflow_o(ovf), .overflow_sticky_o(sticky), .err_clr_i(clr), .drop_cnt_o(cnt)
  );

  fractal_sync_tx_mc #(.N_CHANNELS(1), .FIFO_DEPTH(3), .RSP_W(8), .COMB_IN(1'b1)) u_d3 (
    .clk_i(clk), .rst_i(rst), .rsp_wake_i(b_wake), .rsp_data_i(b_din),
    .check_propagate_o(b_cp), .sampled_data_o(b_sd), .propagate_i(b_prop),
    .valid_o(b_valid), .data_o(b_dout), .ready_i(b_ready), .level_o(b_lvl),
    .overflow_o(b_ovf), .overflow_sticky_o(b_sticky), .err_clr_i(b_clr), .drop_cnt_o(b_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic w; logic [7:0] d; logic [1:0] p; logic [1:0] r; logic cl;
    logic e_cp; logic [7:0] e_sd; logic [1:0] e_v; logic [1:0] e_l0; logic [1:0] e_l1;
    logic [7:0] e_d0; logic [7:0] e_d1; logic [1:0] e_o; logic [1:0] e_s;
    logic [15:0] e_c0; logic [15:0] e_c1;
  } vec_t;

  function automatic vec_t mk(logic w, logic [7:0] d, logic [1:0] p, logic [1:0] r, logic cl,
                              logic ecp, logic [7:0] esd, logic [1:0] ev, logic [1:0] el0,
                              logic [1:0] el1, logic [7:0] ed0, logic [7:0] ed1, logic [1:0] eo,
                              logic [1:0] es, logic [15:0] ec0, logic [15:0] ec1);
    vec_t v;
    v.w = w; v.d = d; v.p = p; v.r = r; v.cl = cl;
    v.e_cp = ecp; v.e_sd = esd; v.e_v = ev; v.e_l0 = el0; v.e_l1 = el1;
    v.e_d0 = ed0; v.e_d1 = ed1; v.e_o = eo; v.e_s = es; v.e_c0 = ec0; v.e_c1 = ec1;
    return v;
  endfunction

  vec_t vt [24];

  typedef logic [7:0] byteq_t [$];
  byteq_t mq [2];
  logic   mw;
  logic [7:0] md;
  logic   mst [2];
  int     mcnt [2];
  logic [7:0] bq [$];

  initial begin
    // wake data prop rdy clr | cp sd valid l0 l1 d0 d1 ovf sticky c0 c1
    vt[0]  = mk(1'b1, 8'hA5, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[1]  = mk(1'b0, 8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 8'hA5, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[2]  = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b11, 2'd1, 2'd1, 8'hA5, 8'hA5, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[3]  = mk(1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 1'b0, 8'h00, 2'b11, 2'd1, 2'd1, 8'hA5, 8'hA5, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[4]  = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[5]  = mk(1'b1, 8'h01, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[6]  = mk(1'b1, 8'h02, 2'b01, 2'b00, 1'b0, 1'b1, 8'h01, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[7]  = mk(1'b1, 8'h03, 2'b01, 2'b00, 1'b0, 1'b1, 8'h02, 2'b01, 2'd1, 2'd0, 8'h01, 8'h00, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[8]  = mk(1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 1'b1, 8'h03, 2'b01, 2'd2, 2'd0, 8'h01, 8'h00, 2'b01, 2'b00, 16'd0, 16'd0);
    vt[9]  = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 2'd2, 2'd0, 8'h01, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[10] = mk(1'b1, 8'h10, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 2'd2, 2'd0, 8'h01, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[11] = mk(1'b0, 8'h00, 2'b01, 2'b01, 1'b0, 1'b1, 8'h10, 2'b01, 2'd2, 2'd0, 8'h01, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[12] = mk(1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b01, 2'd2, 2'd0, 8'h02, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[13] = mk(1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b01, 2'd1, 2'd0, 8'h10, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[14] = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[15] = mk(1'b1, 8'h20, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[16] = mk(1'b1, 8'h21, 2'b10, 2'b00, 1'b0, 1'b1, 8'h20, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[17] = mk(1'b1, 8'h22, 2'b10, 2'b00, 1'b0, 1'b1, 8'h21, 2'b10, 2'd0, 2'd1, 8'h00, 8'h20, 2'b00, 2'b01, 16'd1, 16'd0);
    vt[18] = mk(1'b0, 8'h00, 2'b10, 2'b00, 1'b1, 1'b1, 8'h22, 2'b10, 2'd0, 2'd2, 8'h00, 8'h20, 2'b10, 2'b01, 16'd1, 16'd0);
    vt[19] = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 2'd0, 2'd2, 8'h00, 8'h20, 2'b00, 2'b10, 16'd0, 16'd1);
    vt[20] = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b10, 2'd0, 2'd2, 8'h00, 8'h20, 2'b00, 2'b10, 16'd0, 16'd1);
    vt[21] = mk(1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10, 2'd0, 2'd2, 8'h00, 8'h20, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[22] = mk(1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10, 2'd0, 2'd1, 8'h00, 8'h21, 2'b00, 2'b00, 16'd0, 16'd0);
    vt[23] = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 16'd0, 16'd0);

    rst = 1'b1; wake = 1'b0; din = 8'h00; prop = 2'b00; ready = 2'b00; clr = 1'b0;
    b_wake = 1'b0; b_din = 8'h00; b_prop = 1'b0; b_ready = 1'b0; b_clr = 1'b0;
    #1;
    chk("rst_cp", {31'd0, cp}, 32'd0);
    chk("rst_valid", {30'd0, valid}, 32'd0);
    chk("rst_level", {28'd0, lvl}, 32'd0);
    chk("rst_sticky", {30'd0, sticky}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vector table: scenarios 1, 2, 3 and 6.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      wake = vt[i].w; din = vt[i].d; prop = vt[i].p; ready = vt[i].r; clr = vt[i].cl;
      #1;
      chk($sformatf("v%0d_cp", i), {31'd0, cp}, {31'd0, vt[i].e_cp});
      if (vt[i].e_cp) chk($sformatf("v%0d_sd", i), {24'd0, sd}, {24'd0, vt[i].e_sd});
      chk($sformatf("v%0d_valid", i), {30'd0, valid}, {30'd0, vt[i].e_v});
      chk($sformatf("v%0d_level", i), {28'd0, lvl}, {28'd0, vt[i].e_l1, vt[i].e_l0});
      if (vt[i].e_v[0]) chk($sformatf("v%0d_d0", i), {24'd0, dout[7:0]}, {24'd0, vt[i].e_d0});
      if (vt[i].e_v[1]) chk($sformatf("v%0d_d1", i), {24'd0, dout[15:8]}, {24'd0, vt[i].e_d1});
      chk($sformatf("v%0d_ovf", i), {30'd0, ovf}, {30'd0, vt[i].e_o});
      chk($sformatf("v%0d_sticky", i), {30'd0, sticky}, {30'd0, vt[i].e_s});
      chk($sformatf("v%0d_cnt", i), cnt, CNT_EN ? {vt[i].e_c1, vt[i].e_c0} : 32'd0);
    end

    // Asynchronous reset with two entries queued, then a fresh scenario-1 transaction.
    @(negedge clk); wake = 1'b1; din = 8'h55; prop = 2'b00; ready = 2'b00; clr = 1'b0;
    @(negedge clk); wake = 1'b1; din = 8'h66; prop = 2'b01;
    @(negedge clk); wake = 1'b1; din = 8'h77; prop = 2'b01;
    @(negedge clk); wake = 1'b0; prop = 2'b01;
    #1;
    chk("pre_rst_level", {28'd0, lvl}, 32'd2);
    chk("pre_rst_ovf", {30'd0, ovf}, 32'd1);
    #1; rst = 1'b1; #1;
    chk("mid_rst_valid", {30'd0, valid}, 32'd0);
    chk("mid_rst_level", {28'd0, lvl}, 32'd0);
    chk("mid_rst_ovf", {30'd0, ovf}, 32'd0);
    chk("mid_rst_cp", {31'd0, cp}, 32'd0);
    chk("mid_rst_data", {16'd0, dout}, 32'd0);
    @(negedge clk); rst = 1'b0; wake = 1'b1; din = 8'hA5; prop = 2'b00;
    @(negedge clk); wake = 1'b0; din = 8'h00; prop = 2'b11; #1;
    chk("post_rst_cp", {31'd0, cp}, 32'd1);
    @(negedge clk); prop = 2'b00; #1;
    chk("post_rst_valid", {30'd0, valid}, 32'd3);
    chk("post_rst_data", {16'd0, dout}, 32'h0000A5A5);
    @(negedge clk); ready = 2'b11;
    @(negedge clk); ready = 2'b00; #1;
    chk("post_rst_drained", {28'd0, lvl}, 32'd0);

    // Depth-3, combinational-input instance: ordering across pointer wrap.
    bq.delete();
    for (int i = 0; i < 18; i++) begin
      logic pu, po;
      @(negedge clk);
      b_wake = (i < 10); b_prop = (i < 10); b_din = 8'h30 + 8'(i);
      b_ready = (i >= 10) ? 1'b1 : logic'(i % 2);
      #1;
      pu = b_wake & b_prop;
      po = b_ready && (bq.size() > 0);
      chk($sformatf("w%0d_cp", i), {31'd0, b_cp}, {31'd0, b_wake});
      chk($sformatf("w%0d_level", i), {30'd0, b_lvl}, 32'(bq.size()));
      if (bq.size() > 0) chk($sformatf("w%0d_data", i), {24'd0, b_dout}, {24'd0, bq[0]});
      chk($sformatf("w%0d_ovf", i), {31'd0, b_ovf}, {31'd0, pu && bq.size() == 3 && !po});
      if (po) void'(bq.pop_front());
      if (pu && bq.size() < 3) bq.push_back(b_din);
    end
    b_wake = 1'b0; b_prop = 1'b0; b_ready = 1'b0;
    #1;
    chk("wrap_end_level", {30'd0, b_lvl}, 32'd0);

    // Random traffic against a queue-based model.
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    mw = 1'b0; md = 8'h00;
    for (int c = 0; c < 2; c++) begin mq[c].delete(); mst[c] = 1'b0; mcnt[c] = 0; end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      wake  = ($urandom_range(0, 3) != 0);
      din   = 8'($urandom);
      prop  = 2'($urandom);
      ready = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
      clr   = ($urandom_range(0, 19) == 0);
      #1;
      chk($sformatf("r%0d_cp", k), {31'd0, cp}, {31'd0, mw});
      chk($sformatf("r%0d_sd", k), {24'd0, sd}, {24'd0, md});
      for (int c = 0; c < 2; c++) begin
        int  sz;
        logic pu, po, eo;
        sz = mq[c].size();
        pu = mw & prop[c];
        po = ready[c] && (sz > 0);
        eo = pu && (sz == D) && !po;
        chk($sformatf("r%0d_c%0d_level", k, c), {28'd0, lvl[c*2 +: 2]}, 32'(sz));
        chk($sformatf("r%0d_c%0d_valid", k, c), {31'd0, valid[c]}, {31'd0, sz > 0});
        if (sz > 0) chk($sformatf("r%0d_c%0d_data", k, c), {24'd0, dout[c*8 +: 8]}, {24'd0, mq[c][0]});
        chk($sformatf("r%0d_c%0d_ovf", k, c), {31'd0, ovf[c]}, {31'd0, eo});
        chk($sformatf("r%0d_c%0d_sticky", k, c), {31'd0, sticky[c]}, {31'd0, mst[c]});
        chk($sformatf("r%0d_c%0d_cnt", k, c), {16'd0, cnt[c*16 +: 16]}, CNT_EN ? 32'(mcnt[c]) : 32'd0);
        if (po) void'(mq[c].pop_front());
        if (pu && mq[c].size() < D) mq[c].push_back(md);
        if (eo) mst[c] = 1'b1;
        else if (clr) mst[c] = 1'b0;
        if (clr) mcnt[c] = 0;
        if (eo && mcnt[c] < 65535) mcnt[c] = mcnt[c] + 1;
      end
      if (wake) md = din;
      mw = wake;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
